// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the MEM-stage
// data requester, with data priority and a bounded anti-starvation counter for fetch.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | no transaction; grants one upstream request
  // ADDR  | mem_req high with latched fields; waits for mem_addr_ok
  // DATA  | request accepted downstream; waits for mem_data_ok
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [2:0]  starve_cnt, starve_nxt;
  logic        grant_inst, grant_data;

  logic        lat_is_data;
  logic        lat_wr;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= 3'd0;
      lat_is_data <= 1'b0;
      lat_wr      <= 1'b0;
      lat_wstrb   <= 4'd0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (grant_data) begin
        lat_is_data <= 1'b1;
        lat_wr      <= data_wr;
        lat_wstrb   <= data_wstrb;
        lat_addr    <= data_addr;
        lat_wdata   <= data_wdata;
      end else if (grant_inst) begin
        lat_is_data <= 1'b0;
        lat_wr      <= 1'b0;
        lat_wstrb   <= 4'd0;
        lat_addr    <= inst_addr;
        lat_wdata   <= 32'd0;
      end
    end
  end

  // Everything is gated by !rst so a reset cycle emits no handshakes at all,
  // including a data_ok for a transaction that is being dropped.
  always_comb begin
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_wstrb    = 4'd0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;

    if (!rst) begin
      case (state)
        IDLE: begin
          if (data_req && !(inst_req && (starve_cnt == STARVE_MAX))) begin
            grant_data = 1'b1;
          end else if (inst_req) begin
            grant_inst = 1'b1;
          end

          if (grant_inst) begin
            starve_nxt = 3'd0;
          end else if (grant_data && inst_req && (starve_cnt != STARVE_MAX)) begin
            starve_nxt = starve_cnt + 3'd1;
          end

          inst_addr_ok = grant_inst;
          data_addr_ok = grant_data;
          if (grant_inst || grant_data) begin
            state_nxt = ADDR;
          end
        end

        ADDR: begin
          mem_req   = 1'b1;
          mem_wr    = lat_wr;
          mem_wstrb = lat_wstrb;
          mem_addr  = lat_addr;
          mem_wdata = lat_wdata;
          if (mem_addr_ok) begin
            state_nxt = DATA;
          end
        end

        DATA: begin
          if (mem_data_ok) begin
            state_nxt = IDLE;
            if (lat_is_data) begin
              data_data_ok = 1'b1;
              data_rdata   = mem_rdata;
            end else begin
              inst_data_ok = 1'b1;
              inst_rdata   = mem_rdata;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle-stepped memory model drives
// the downstream port; expected responses are queued at stimulus and popped on data_ok.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        who;    // 1 = data, 0 = inst
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t obs_q[$];
  int   grant_q[$];
  int   grant_cyc_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          addr_delay = 0;
  int          data_delay = 0;
  int          a_cnt = 0;
  int          d_cnt = 0;
  bit          busy = 0;
  bit          real_dok = 0;
  bit          stray_dok = 0;
  bit          stray_aok = 0;
  logic [31:0] rsp_val = 32'd0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1C00_0100) return 32'hDEAD_BEEF;
    return (a ^ 32'h5A5A_A5A5) + 32'd7;
  endfunction

  function automatic rsp_t mk(input logic who, input logic [31:0] rdata);
    rsp_t r;
    r.who   = who;
    r.rdata = rdata;
    return r;
  endfunction

  // Drive the memory model for this cycle, let the DUT settle, record events.
  task automatic settle();
    #1;
    mem_addr_ok = (mem_req && (a_cnt >= addr_delay)) || stray_aok;
    real_dok    = busy && (d_cnt >= data_delay);
    mem_data_ok = real_dok || stray_dok;
    mem_rdata   = real_dok ? rsp_val : (stray_dok ? 32'hBAD0_BAD0 : 32'd0);
    #1;
    if (inst_addr_ok && data_addr_ok) begin
      grant_q.push_back(2);
      grant_cyc_q.push_back(cyc);
    end else if (inst_addr_ok) begin
      grant_q.push_back(0);
      grant_cyc_q.push_back(cyc);
    end else if (data_addr_ok) begin
      grant_q.push_back(1);
      grant_cyc_q.push_back(cyc);
    end
    if (inst_data_ok) obs_q.push_back(mk(1'b0, inst_rdata));
    if (data_data_ok) obs_q.push_back(mk(1'b1, data_rdata));
  endtask

  // Advance the memory model with what the DUT sees at the coming edge.
  task automatic tick();
    if (rst) begin
      busy  = 0;
      a_cnt = 0;
    end else begin
      if (busy && real_dok) busy = 0;
      else if (busy) d_cnt++;
      if (mem_req && mem_addr_ok) begin
        busy    = 1;
        d_cnt   = 0;
        a_cnt   = 0;
        rsp_val = mem_fn(mem_addr);
      end else if (mem_req) begin
        a_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_inputs();
    inst_req   = 1'b0;
    inst_addr  = 32'd0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    stray_dok  = 0;
    stray_aok  = 0;
  endtask

  task automatic test_reset();
    rsp_t e, o;
    rst        = 1'b1;
    inst_req   = 1'b1;
    inst_addr  = 32'h0000_0040;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'hF;
    data_addr  = 32'h0000_0080;
    data_wdata = 32'hFFFF_FFFF;
    stray_dok  = 1;
    stray_aok  = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req} !== 5'b0) begin
        errors++;
        $display("FAIL reset_handshakes[%0d]: got %b, expected 00000", i,
                 {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req});
      end
      checks++;
      if ({inst_rdata, data_rdata, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== 101'd0) begin
        errors++;
        $display("FAIL reset_buses[%0d]: inst_rdata=%h data_rdata=%h mem_addr=%h mem_wdata=%h, expected all 0",
                 i, inst_rdata, data_rdata, mem_addr, mem_wdata);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b, expected 000", {inst_addr_ok, data_addr_ok, mem_req});
    end
    tick();
    checks++;
    if (grant_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_events: got %0d grants %0d responses, expected 0 0",
               grant_q.size(), obs_q.size());
    end
    grant_q.delete();
    grant_cyc_q.delete();
    sb_q.delete();
    obs_q.delete();
    e = mk(1'b0, 32'd0);
    o = e;
  endtask

  task automatic test_single_load();
    rsp_t e, o;
    addr_delay = 0;
    data_delay = 0;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_addr  = 32'h1C00_0100;
    settle();
    checks++;
    if ({data_addr_ok, inst_addr_ok, mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL load_c0_grant: got addr_ok/inst_addr_ok/mem_req=%b, expected 100",
               {data_addr_ok, inst_addr_ok, mem_req});
    end
    sb_q.push_back(mk(1'b1, 32'hDEAD_BEEF));
    tick();
    clear_inputs();
    settle();
    checks++;
    if ({mem_req, mem_wr, mem_addr, data_addr_ok} !== {1'b1, 1'b0, 32'h1C00_0100, 1'b0}) begin
      errors++;
      $display("FAIL load_c1_mem: got req=%b wr=%b addr=%h addr_ok=%b, expected 1 0 1c000100 0",
               mem_req, mem_wr, mem_addr, data_addr_ok);
    end
    tick();
    settle();
    checks++;
    if ({data_data_ok, data_rdata, mem_req} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL load_c2_resp: got data_ok=%b rdata=%h mem_req=%b, expected 1 deadbeef 0",
               data_data_ok, data_rdata, mem_req);
    end
    tick();
    settle();
    checks++;
    if ({data_data_ok, data_rdata} !== 33'd0) begin
      errors++;
      $display("FAIL load_c3_quiet: got data_ok=%b rdata=%h, expected 0 0", data_data_ok, data_rdata);
    end
    tick();
    checks++;
    if (obs_q.size() != sb_q.size()) begin
      errors++;
      $display("FAIL load_count: got %0d responses, expected %0d", obs_q.size(), sb_q.size());
    end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.who !== e.who || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL load_sb: got who=%b rdata=%h, expected who=%b rdata=%h", o.who, o.rdata, e.who, e.rdata);
      end
    end
    sb_q.delete();
    obs_q.delete();
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  task automatic test_store_stall();
    rsp_t e, o;
    int lat;
    addr_delay = 3;
    data_delay = 2;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'hF;
    data_addr  = 32'h1C00_0200;
    data_wdata = 32'h1234_5678;
    settle();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL store_grant: got data_addr_ok=%b, expected 1", data_addr_ok);
    end
    sb_q.push_back(mk(1'b1, mem_fn(32'h1C00_0200)));
    tick();
    // Upstream keeps requesting with different fields; the latched ones must not move.
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_wstrb = 4'h3;
    data_addr  = 32'hFFFF_0000;
    data_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, 4'hF, 32'h1C00_0200, 32'h1234_5678}) begin
        errors++;
        $display("FAIL store_hold[%0d]: got req=%b wr=%b wstrb=%h addr=%h wdata=%h, expected 1 1 f 1c000200 12345678",
                 i, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata);
      end
      checks++;
      if (data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL store_no_addr_ok[%0d]: got %b, expected 0", i, data_addr_ok);
      end
      tick();
    end
    clear_inputs();
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (obs_q.size() > 0) begin
        lat = i;
        tick();
        break;
      end
      tick();
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL store_resp_latency: got %0d cycles in DATA, expected 2", lat);
    end
    settle();
    checks++;
    if (data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL store_single_ok: got data_ok=%b, expected 0", data_data_ok);
    end
    tick();
    checks++;
    if (obs_q.size() != sb_q.size()) begin
      errors++;
      $display("FAIL store_count: got %0d responses, expected %0d", obs_q.size(), sb_q.size());
    end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.who !== e.who || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL store_sb: got who=%b rdata=%h, expected who=%b rdata=%h", o.who, o.rdata, e.who, e.rdata);
      end
    end
    sb_q.delete();
    obs_q.delete();
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  task automatic test_contention();
    rsp_t e, o;
    int exp_who;
    addr_delay = 0;
    data_delay = 0;
    inst_addr  = 32'h0000_1000;
    data_addr  = 32'h0000_2000;
    data_wr    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_who = (k % 5 == 4) ? 0 : 1;
      sb_q.push_back(mk(exp_who[0], mem_fn(exp_who == 1 ? 32'h0000_2000 : 32'h0000_1000)));
    end
    for (int i = 0; i < 60 && obs_q.size() < 10; i++) begin
      inst_req = (grant_q.size() < 10);
      data_req = (grant_q.size() < 10);
      settle();
      tick();
    end
    clear_inputs();
    checks++;
    if (grant_q.size() != 10) begin
      errors++;
      $display("FAIL contention_grants: got %0d grants, expected 10", grant_q.size());
    end
    for (int k = 0; k < grant_q.size() && k < 10; k++) begin
      exp_who = (k % 5 == 4) ? 0 : 1;
      checks++;
      if (grant_q[k] != exp_who) begin
        errors++;
        $display("FAIL contention_order[%0d]: got grant %0d, expected %0d (1=data 0=inst)", k, grant_q[k], exp_who);
      end
    end
    for (int k = 1; k < grant_cyc_q.size(); k++) begin
      checks++;
      if (grant_cyc_q[k] - grant_cyc_q[k-1] != 3) begin
        errors++;
        $display("FAIL contention_spacing[%0d]: got %0d cycles, expected 3", k, grant_cyc_q[k] - grant_cyc_q[k-1]);
      end
    end
    checks++;
    if (obs_q.size() != sb_q.size()) begin
      errors++;
      $display("FAIL contention_count: got %0d responses, expected %0d", obs_q.size(), sb_q.size());
    end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.who !== e.who || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL contention_sb: got who=%b rdata=%h, expected who=%b rdata=%h", o.who, o.rdata, e.who, e.rdata);
      end
    end
    sb_q.delete();
    obs_q.delete();
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  task automatic test_stray();
    rsp_t e, o;
    addr_delay = 2;
    data_delay = 0;
    stray_dok  = 1;
    stray_aok  = 1;
    settle();
    checks++;
    if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata, mem_req} !== 67'd0) begin
      errors++;
      $display("FAIL stray_idle: got data_ok=%b%b rdata=%h/%h mem_req=%b, expected all 0",
               inst_data_ok, data_data_ok, inst_rdata, data_rdata, mem_req);
    end
    tick();
    clear_inputs();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_3000;
    settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL stray_grant_after_idle: got inst/data addr_ok=%b, expected 10", {inst_addr_ok, data_addr_ok});
    end
    sb_q.push_back(mk(1'b0, mem_fn(32'h0000_3000)));
    tick();
    clear_inputs();
    stray_dok = 1;
    settle();
    checks++;
    if ({mem_req, inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {1'b1, 66'd0}) begin
      errors++;
      $display("FAIL stray_addr: got mem_req=%b data_ok=%b%b rdata=%h/%h, expected 1 00 0/0",
               mem_req, inst_data_ok, data_data_ok, inst_rdata, data_rdata);
    end
    tick();
    stray_dok = 0;
    settle();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL stray_addr_holds: got mem_req=%b, expected 1", mem_req);
    end
    tick();
    for (int i = 0; i < 10 && obs_q.size() == 0; i++) begin
      settle();
      tick();
    end
    checks++;
    if (obs_q.size() != sb_q.size()) begin
      errors++;
      $display("FAIL stray_count: got %0d responses, expected %0d", obs_q.size(), sb_q.size());
    end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.who !== e.who || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL stray_sb: got who=%b rdata=%h, expected who=%b rdata=%h", o.who, o.rdata, e.who, e.rdata);
      end
    end
    sb_q.delete();
    obs_q.delete();
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  task automatic test_reset_mid();
    rsp_t e, o;
    addr_delay = 0;
    data_delay = 0;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_addr  = 32'h0000_4000;
    settle();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: got data_addr_ok=%b, expected 1", data_addr_ok);
    end
    tick();
    clear_inputs();
    settle();
    tick();
    // In DATA with memory answering right now; reset must swallow it.
    rst = 1'b1;
    settle();
    checks++;
    if ({inst_data_ok, data_data_ok, data_rdata, inst_addr_ok, data_addr_ok, mem_req} !== 38'd0) begin
      errors++;
      $display("FAIL rstmid_in_reset: got data_ok=%b%b rdata=%h addr_ok=%b%b mem_req=%b, expected all 0",
               inst_data_ok, data_data_ok, data_rdata, inst_addr_ok, data_addr_ok, mem_req);
    end
    tick();
    rst       = 1'b0;
    stray_dok = 1;
    settle();
    checks++;
    if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata, mem_req, mem_addr} !== 99'd0) begin
      errors++;
      $display("FAIL rstmid_after: got data_ok=%b%b rdata=%h/%h mem_req=%b mem_addr=%h, expected all 0",
               inst_data_ok, data_data_ok, inst_rdata, data_rdata, mem_req, mem_addr);
    end
    tick();
    clear_inputs();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_5000;
    settle();
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_new_grant: got inst/data addr_ok=%b, expected 10", {inst_addr_ok, data_addr_ok});
    end
    sb_q.push_back(mk(1'b0, mem_fn(32'h0000_5000)));
    tick();
    clear_inputs();
    for (int i = 0; i < 10 && obs_q.size() == 0; i++) begin
      settle();
      tick();
    end
    checks++;
    if (obs_q.size() != sb_q.size()) begin
      errors++;
      $display("FAIL rstmid_count: got %0d responses, expected %0d", obs_q.size(), sb_q.size());
    end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.who !== e.who || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL rstmid_sb: got who=%b rdata=%h, expected who=%b rdata=%h", o.who, o.rdata, e.who, e.rdata);
      end
    end
    sb_q.delete();
    obs_q.delete();
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_load();
    test_store_stall();
    test_contention();
    test_stray();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester and the MEM-stage data requester, which drives write_en/write_we/write_addr/write_data. The arbiter holds one outstanding transaction at a time, sequenced by a three-state FSM. Data requests have priority, and an anti-starvation counter keeps fetch progressing. It sits between the pipeline stages and the memory port.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive data grants taken while an inst request waited; at this count the next grant goes to inst.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request (read only)
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response this cycle (load data or store completion)
- data_rdata  out  32  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream read data

## Operation
- FSM states:
  - IDLE: no transaction; accepts an upstream request.
  - ADDR: mem_req=1 with latched fields; waits for mem_addr_ok.
  - DATA: mem_req=0; waits for mem_data_ok.
- Grant in IDLE:
  - If only data_req: grant data.
  - If only inst_req: grant inst.
  - If both: grant data, unless starve_cnt == STARVE_LIMIT, then grant inst.
- On grant (IDLE only):
  - Combinationally pulse the grantee's addr_ok for that cycle.
  - Latch wr/wstrb/addr/wdata and the grant id (inst: wr=0, wstrb=0, wdata=0).
  - Next state is ADDR.
- ADDR: when mem_addr_ok=1, go to DATA.
- DATA: when mem_data_ok=1:
  - Pulse the grant-id's data_ok combinationally.
  - Drive its rdata = mem_rdata.
  - Go to IDLE.
- Non-granted *_addr_ok and *_data_ok are always 0. addr_ok is never asserted outside IDLE.
- starve_cnt: 3 bits, clamped at STARVE_LIMIT.
  - Increments on a data grant while inst_req=1.
  - Clears on any inst grant.
  - Otherwise holds.
- mem_data_ok seen in IDLE or ADDR is ignored (no upstream data_ok).
- mem_addr_ok seen outside ADDR is ignored.
- inst_rdata and data_rdata carry mem_rdata when their data_ok is 1; otherwise they are 0.

## Timing
- Reset:
  - state=IDLE, starve_cnt=0, latched fields=0.
  - All outputs 0 while rst=1. No addr_ok is given in a reset cycle.
- Minimum latency, with req at cycle 0 and zero-wait memory:
  - cycle 0: addr_ok.
  - cycle 1: mem_req with mem_addr_ok.
  - cycle 2: DATA; mem_data_ok gives upstream data_ok in the same cycle.
  - Total: 3 cycles from request to response.
- Back-to-back: the next grant is possible in the cycle after data_ok (IDLE). Throughput is at most one transaction per 3 cycles.
- mem_req and its fields stay stable from entry to ADDR until the cycle mem_addr_ok is sampled high.
- Upstream fields need only be valid in the grant cycle.
- Reset during ADDR or DATA:
  - Return to IDLE next edge and drop the transaction.
  - No data_ok is issued for it. A later stray mem_data_ok is ignored by rule.
- Simultaneous inst_req and data_req with starve_cnt < STARVE_LIMIT: data wins; inst_addr_ok=0.

## Test plan
- Single load, zero-wait memory: data_req=1, data_wr=0, addr=0x1C000100 at cycle 0.
  - Response: data_addr_ok at cycle 0; mem_req/mem_addr=0x1C000100 at cycle 1; data_data_ok=1 with data_rdata=mem_rdata=0xDEADBEEF at cycle 2.
- Store, memory stall: data_wr=1, wstrb=0xF, wdata=0x12345678, mem_addr_ok delayed 3 cycles.
  - Response: mem_req and fields held constant for 4 cycles; data_data_ok once mem_data_ok arrives.
- Contention: inst_req and data_req held high continuously.
  - Response: grant order is data×4, inst, data×4, inst…; starve_cnt returns to 0 after each inst grant.
- Stray responses: mem_data_ok=1 pulsed in IDLE and in ADDR.
  - Response: no upstream data_ok; state unchanged by it.
- Reset mid-transaction: rst=1 for one cycle while in DATA.
  - Response: next cycle IDLE, all outputs 0.
  - A subsequent mem_data_ok produces no data_ok.
  - A new inst_req is granted normally.
